// File: rtl/md_io_regs.sv
// I/O port register block: version, 3 x (data, ctrl, serial) registers, TH interrupt.
// Latency: writes commit and read data loads in the access cycle; cpu_dtack follows one cycle later.
// Backpressure: one access per cpu_sel strobe; cpu_dtack holds while cpu_sel stays high.
module md_io_regs #(
  parameter logic [3:0] HW_VER = 4'h0,
  parameter bit         NO_EXP = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       overseas,
  input  logic       pal,
  input  logic       cpu_sel,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_dtack,
  output logic [6:0] p1_out,
  output logic [6:0] p2_out,
  output logic [6:0] p3_out,
  output logic [6:0] p1_dir,
  output logic [6:0] p2_dir,
  output logic [6:0] p3_dir,
  input  logic [6:0] p1_in,
  input  logic [6:0] p2_in,
  input  logic [6:0] p3_in,
  output logic       ext_int,
  input  logic       int_ack
);

  // Register kinds selected by cpu_addr
  typedef enum logic [2:0] {
    R_VER   = 3'd0,
    R_DATA  = 3'd1,
    R_CTRL  = 3'd2,
    R_TXD   = 3'd3,
    R_RXD   = 3'd4,
    R_SCTRL = 3'd5
  } reg_kind_e;

  // Per-port state, index 0..2 = port 1..3
  logic [2:0][7:0] data_q,  data_d;
  logic [2:0][7:0] ctrl_q,  ctrl_d;
  logic [2:0][7:0] txd_q,   txd_d;
  logic [2:0][7:0] sctrl_q, sctrl_d;
  logic [2:0]      th_q,    th_d;

  logic            dtack_q,   dtack_d;
  logic [7:0]      dout_q,    dout_d;
  logic            ext_int_q, ext_int_d;

  logic [2:0][6:0] pin;
  reg_kind_e       kind;
  logic [1:0]      idx;
  logic            access;
  logic [7:0]      rd_dat;
  logic [2:0]      th_event;

  assign pin = {p3_in, p2_in, p1_in};

  // Access cycle: first clock with the strobe up and no acknowledge yet outstanding
  assign access = cpu_sel & ~dtack_q;

  // Address decode into register kind and port index
  always_comb begin
    kind = R_VER;
    idx  = 2'd0;
    case (cpu_addr)
      4'h0: begin kind = R_VER;   idx = 2'd0; end
      4'h1: begin kind = R_DATA;  idx = 2'd0; end
      4'h2: begin kind = R_DATA;  idx = 2'd1; end
      4'h3: begin kind = R_DATA;  idx = 2'd2; end
      4'h4: begin kind = R_CTRL;  idx = 2'd0; end
      4'h5: begin kind = R_CTRL;  idx = 2'd1; end
      4'h6: begin kind = R_CTRL;  idx = 2'd2; end
      4'h7: begin kind = R_TXD;   idx = 2'd0; end
      4'h8: begin kind = R_RXD;   idx = 2'd0; end
      4'h9: begin kind = R_SCTRL; idx = 2'd0; end
      4'hA: begin kind = R_TXD;   idx = 2'd1; end
      4'hB: begin kind = R_RXD;   idx = 2'd1; end
      4'hC: begin kind = R_SCTRL; idx = 2'd1; end
      4'hD: begin kind = R_TXD;   idx = 2'd2; end
      4'hE: begin kind = R_RXD;   idx = 2'd2; end
      4'hF: begin kind = R_SCTRL; idx = 2'd2; end
      default: begin kind = R_VER; idx = 2'd0; end
    endcase
  end

  // Read mux; data bits configured as inputs return the live pin level
  always_comb begin
    rd_dat = 8'h00;
    case (kind)
      R_VER:   rd_dat = {overseas, pal, NO_EXP, 1'b0, HW_VER};
      R_DATA:  rd_dat = {data_q[idx][7],
                         (data_q[idx][6:0] & ctrl_q[idx][6:0]) |
                         (pin[idx] & ~ctrl_q[idx][6:0])};
      R_CTRL:  rd_dat = ctrl_q[idx];
      R_TXD:   rd_dat = txd_q[idx];
      R_RXD:   rd_dat = 8'h00;
      R_SCTRL: rd_dat = {sctrl_q[idx][7:3], 3'b000};
      default: rd_dat = 8'h00;
    endcase
  end

  // Handshake and read-data next state
  always_comb begin
    dtack_d = cpu_sel;
    dout_d  = dout_q;
    if (access && !cpu_we) begin
      dout_d = rd_dat;
    end
  end

  // Register write decode; version and RXD writes fall through untouched
  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    txd_d   = txd_q;
    sctrl_d = sctrl_q;
    if (access && cpu_we) begin
      case (kind)
        R_DATA:  data_d[idx]  = cpu_din;
        R_CTRL:  ctrl_d[idx]  = cpu_din;
        R_TXD:   txd_d[idx]   = cpu_din;
        R_SCTRL: sctrl_d[idx] = {cpu_din[7:3], 3'b000};
        default: ;
      endcase
    end
  end

  // TH falling-edge detect; uses the pre-write CTRL so a same-cycle enable does not fire
  always_comb begin
    th_d     = '0;
    th_event = '0;
    for (int k = 0; k < 3; k++) begin
      th_d[k]     = pin[k][6];
      th_event[k] = th_q[k] & ~pin[k][6] & ~ctrl_q[k][6] & ctrl_q[k][7];
    end
  end

  // Interrupt is sticky: a new event outranks a same-cycle acknowledge
  always_comb begin
    ext_int_d = (|th_event) | (ext_int_q & ~int_ack);
  end

  // Bus handshake and read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dtack_q <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      dtack_q <= dtack_d;
      dout_q  <= dout_d;
    end
  end

  // Per-port configuration and data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      txd_q   <= {3{8'hFF}};
      sctrl_q <= '0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      txd_q   <= txd_d;
      sctrl_q <= sctrl_d;
    end
  end

  // TH history and interrupt request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      th_q      <= 3'b111;
      ext_int_q <= 1'b0;
    end else begin
      th_q      <= th_d;
      ext_int_q <= ext_int_d;
    end
  end

  assign cpu_dout  = dout_q;
  assign cpu_dtack = dtack_q;
  assign ext_int   = ext_int_q;

  assign p1_out = data_q[0][6:0];
  assign p2_out = data_q[1][6:0];
  assign p3_out = data_q[2][6:0];
  assign p1_dir = ctrl_q[0][6:0];
  assign p2_dir = ctrl_q[1][6:0];
  assign p3_dir = ctrl_q[2][6:0];

endmodule

// File: tb/tb_md_io_regs.sv
// Bench for md_io_regs: directed scenarios then randomized bus traffic against a register-map model.
module tb_md_io_regs;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       overseas, pal;
  logic       cpu_sel, cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_din;
  wire  [7:0] cpu_dout;
  wire        cpu_dtack;
  wire  [6:0] pout [3];
  wire  [6:0] pdir [3];
  logic [6:0] pin  [3];
  wire        ext_int;
  logic       int_ack;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_data [3];
  logic [7:0] m_ctrl [3];
  logic [7:0] m_txd  [3];
  logic [7:0] m_sctrl[3];
  logic       m_th   [3];
  logic       m_int, m_dtack;
  logic [7:0] m_dout;
  bit         rnd_mode = 1'b0;
  logic [7:0] rd;

  md_io_regs #(.HW_VER(4'h1), .NO_EXP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .overseas(overseas), .pal(pal),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_dtack(cpu_dtack),
    .p1_out(pout[0]), .p2_out(pout[1]), .p3_out(pout[2]),
    .p1_dir(pdir[0]), .p2_dir(pdir[1]), .p3_dir(pdir[2]),
    .p1_in(pin[0]), .p2_in(pin[1]), .p3_in(pin[2]),
    .ext_int(ext_int), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_data[k] = 8'h00; m_ctrl[k] = 8'h00; m_txd[k] = 8'hFF; m_sctrl[k] = 8'h00;
      m_th[k] = 1'b1;
    end
    m_int = 1'b0; m_dtack = 1'b0; m_dout = 8'h00;
  endtask

  // Register map read, straight from the address table
  function automatic logic [7:0] m_read(input logic [3:0] a);
    int ai = int'(a);
    int k;
    if (ai == 0) return {overseas, pal, 1'b1, 1'b0, 4'h1};
    if (ai <= 3) begin
      k = ai - 1;
      return {m_data[k][7], (m_data[k][6:0] & m_ctrl[k][6:0]) | (pin[k] & ~m_ctrl[k][6:0])};
    end
    if (ai <= 6) return m_ctrl[ai - 4];
    k = (ai - 7) / 3;
    case ((ai - 7) % 3)
      0:       return m_txd[k];
      1:       return 8'h00;
      default: return m_sctrl[k] & 8'hF8;
    endcase
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    int ai = int'(a);
    int k;
    if (ai == 0) return;
    if (ai <= 3) begin m_data[ai - 1] = d; return; end
    if (ai <= 6) begin m_ctrl[ai - 4] = d; return; end
    k = (ai - 7) / 3;
    case ((ai - 7) % 3)
      0:       m_txd[k] = d;
      2:       m_sctrl[k] = d & 8'hF8;
      default: ;
    endcase
  endtask

  task automatic check_outs();
    chk("dtack",   8'(cpu_dtack), 8'(m_dtack));
    chk("dout",    cpu_dout, m_dout);
    chk("ext_int", 8'(ext_int), 8'(m_int));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("p%0d_out", k + 1), 8'(pout[k]), 8'(m_data[k][6:0]));
      chk($sformatf("p%0d_dir", k + 1), 8'(pdir[k]), 8'(m_ctrl[k][6:0]));
    end
  endtask

  // One clock: model predicts from inputs present before the edge, outputs compared at the next negedge
  task automatic cyc();
    logic acc, ev, nxt_int;
    logic [7:0] rv;
    if (rnd_mode) begin
      for (int k = 0; k < 3; k++) pin[k] = 7'($urandom);
      int_ack  = ($urandom_range(0, 3) == 0);
      overseas = 1'($urandom);
      pal      = 1'($urandom);
    end
    acc = cpu_sel && !m_dtack;
    ev  = 1'b0;
    for (int k = 0; k < 3; k++)
      if (m_th[k] && !pin[k][6] && !m_ctrl[k][6] && m_ctrl[k][7]) ev = 1'b1;
    nxt_int = ev | (m_int & ~int_ack);
    rv = (acc && !cpu_we) ? m_read(cpu_addr) : m_dout;
    @(posedge clk);
    if (acc && cpu_we) m_write(cpu_addr, cpu_din);
    for (int k = 0; k < 3; k++) m_th[k] = pin[k][6];
    m_int = nxt_int; m_dout = rv; m_dtack = cpu_sel;
    @(negedge clk);
    check_outs();
  endtask

  // Full bus cycle: access, hold extra cycles, release strobe
  task automatic bus(input logic we, input logic [3:0] a, input logic [7:0] d,
                     input int hold, output logic [7:0] rdat);
    cpu_sel = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    cyc();
    rdat = cpu_dout;
    chk("dtack_after_access", 8'(cpu_dtack), 8'h01);
    for (int i = 0; i < hold; i++) cyc();
    cpu_sel = 1'b0;
    cyc();
    chk("dtack_release", 8'(cpu_dtack), 8'h00);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; overseas = 1'b1; pal = 1'b0;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_din = 8'h00; int_ack = 1'b0;
    for (int k = 0; k < 3; k++) pin[k] = 7'h00;
    model_reset();
    @(negedge clk);
    check_outs();
    chk("rst_dout", cpu_dout, 8'h00);
    reset_n = 1'b1;
    cyc();

    // Version register, writes ignored
    bus(1'b0, 4'h0, 8'h00, 0, rd);
    chk("version", rd, 8'hA1);
    bus(1'b1, 4'h0, 8'h5F, 0, rd);
    bus(1'b0, 4'h0, 8'h00, 0, rd);
    chk("version_after_write", rd, 8'hA1);

    // Mixed-direction data port
    pin[0] = 7'h15;
    bus(1'b1, 4'h4, 8'h40, 0, rd);
    bus(1'b1, 4'h1, 8'h40, 0, rd);
    chk("p1_dir_mixed", 8'(pdir[0]), 8'h40);
    chk("p1_out_mixed", 8'(pout[0]), 8'h40);
    bus(1'b0, 4'h1, 8'h00, 0, rd);
    chk("data1_mixed", rd, 8'h55);

    // TH interrupt on port 2, sticky until acknowledged
    bus(1'b1, 4'h5, 8'h80, 0, rd);
    pin[1] = 7'h40; cyc();
    pin[1] = 7'h00; cyc();
    chk("p2_th_int", 8'(ext_int), 8'h01);
    repeat (3) cyc();
    chk("p2_int_held", 8'(ext_int), 8'h01);
    pulse_ack();
    chk("p2_int_acked", 8'(ext_int), 8'h00);

    // Port 3: ack colliding with a new edge keeps the request
    bus(1'b1, 4'h6, 8'h80, 0, rd);
    pin[2] = 7'h40; cyc();
    pin[2] = 7'h00; cyc();
    chk("p3_int", 8'(ext_int), 8'h01);
    pin[2] = 7'h40; cyc();
    pin[2] = 7'h00; int_ack = 1'b1; cyc(); int_ack = 1'b0;
    chk("ack_collision", 8'(ext_int), 8'h01);
    // Disabling the enable does not drop a pending request
    bus(1'b1, 4'h6, 8'h00, 0, rd);
    chk("disable_keeps_int", 8'(ext_int), 8'h01);
    pulse_ack();
    chk("int_cleared", 8'(ext_int), 8'h00);

    // Enable written in the same cycle as a TH fall does not fire
    bus(1'b1, 4'h4, 8'h00, 0, rd);
    pin[0] = 7'h40; cyc();
    pin[0] = 7'h00;
    bus(1'b1, 4'h4, 8'h80, 1, rd);
    chk("enable_same_cycle", 8'(ext_int), 8'h00);
    bus(1'b1, 4'h4, 8'h00, 0, rd);

    // Long strobe: single commit
    bus(1'b1, 4'h7, 8'h3C, 9, rd);
    bus(1'b0, 4'h7, 8'h00, 0, rd);
    chk("txd1_long", rd, 8'h3C);
    bus(1'b1, 4'h8, 8'h99, 0, rd);
    bus(1'b0, 4'h8, 8'h00, 0, rd);
    chk("rxd1_zero", rd, 8'h00);
    bus(1'b1, 4'h9, 8'hFF, 0, rd);
    bus(1'b0, 4'h9, 8'h00, 0, rd);
    chk("sctrl1_mask", rd, 8'hF8);

    // Reset in the middle of a DATA1 write
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h1; cpu_din = 8'h5A;
    cyc();
    chk("pre_rst_p1_out", 8'(pout[0]), 8'h5A);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_dtack", 8'(cpu_dtack), 8'h00);
    chk("rst_mid_p1_out", 8'(pout[0]), 8'h00);
    check_outs();
    @(posedge clk); @(negedge clk);
    check_outs();
    reset_n = 1'b1; cpu_din = 8'h33;
    cyc();
    chk("rst_fresh_dtack", 8'(cpu_dtack), 8'h01);
    chk("rst_fresh_p1_out", 8'(pout[0]), 8'h33);
    cpu_sel = 1'b0; cyc();
    bus(1'b0, 4'h7, 8'h00, 0, rd);
    chk("rst_txd1", rd, 8'hFF);

    // Randomized traffic with random pins, acks and strap inputs
    rnd_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) cyc();
      bus(1'($urandom), 4'($urandom), 8'($urandom), $urandom_range(0, 3), rd);
    end
    rnd_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_io_regs.md
MD_IO_REGS -- requirements
Module: md_io_regs

Interface
REQ-001 SHALL have parameter HW_VER, default 4'h0; the 4-bit hardware version reported in the version register bits [3:0].
REQ-002 SHALL have parameter NO_EXP, default 1; drives version bit 5 (1 = no expansion unit fitted).
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port overseas  in  1  copied to version bit 7.
REQ-006 SHALL have port pal  in  1  copied to version bit 6.
REQ-007 SHALL have port cpu_sel  in  1  bus cycle strobe, held high until cpu_dtack is seen.
REQ-008 SHALL have port cpu_we  in  1  1 = write, 0 = read; stable while cpu_sel is high.
REQ-009 SHALL have port cpu_addr  in  4  register index, word address bits A[4:1].
REQ-010 SHALL have port cpu_din  in  8  write data.
REQ-011 SHALL have port cpu_dout  out  8  read data, registered.
REQ-012 SHALL have port cpu_dtack  out  1  cycle acknowledge.
REQ-013 SHALL have ports p1_out, p2_out, p3_out  out  7 each  data-register pin values (bits 6:0), fed to the pad stage port_in.
REQ-014 SHALL have ports p1_dir, p2_dir, p3_dir  out  7 each  pin direction, 1 = output, fed to the pad stage port_dir.
REQ-015 SHALL have ports p1_in, p2_in, p3_in  in  7 each  resolved pin levels, from the pad stage port_out.
REQ-016 SHALL have port ext_int  out  1  level external-interrupt request.
REQ-017 SHALL have port int_ack  in  1  one-cycle pulse that clears ext_int.

Function
REQ-018 Register map (cpu_addr) SHALL be:
- 0: version
- 1-3: DATA1-3
- 4-6: CTRL1-3
- 7/A/D: TXD1-3
- 8/B/E: RXD1-3
- 9/C/F: SCTRL1-3
REQ-019 The version register SHALL read {overseas, pal, NO_EXP, 1'b0, HW_VER} and SHALL ignore writes.
REQ-020 DATAk read SHALL return bit 7 from the stored data register; for each bit i in 6:0: stored bit when dirk[i]=1, else pk_in[i].
REQ-021 pk_out SHALL equal stored DATAk[6:0]; pk_dir SHALL equal CTRLk[6:0]; both continuously.
REQ-022 CTRLk, TXDk and SCTRLk SHALL read back their stored value; SCTRLk bits [2:0] SHALL read as 0 and are not writable.
REQ-023 RXDk SHALL read 0x00 and SHALL ignore writes.
REQ-024 Bus handshake: the first clock with cpu_sel=1 and cpu_dtack=0 is the access cycle.
- Write: commits in the access cycle.
- Read: cpu_dout loads in the access cycle.
- cpu_dtack=1 from the next cycle, held while cpu_sel=1, 0 one cycle after cpu_sel falls.
REQ-025 Each bus cycle SHALL perform exactly one access, however long cpu_sel is held.
REQ-026 A write to DATAk or CTRLk SHALL be visible on pk_out/pk_dir in the cycle after the access cycle.
REQ-027 TH edge detection: per port, register THk_d <= pk_in[6] every cycle.
- A TH event is THk_d=1 and pk_in[6]=0 with CTRLk[6]=0 (TH is an input) and CTRLk[7]=1 (interrupt enabled).
REQ-028 Any TH event on any port SHALL set ext_int on the next cycle.
- int_ack=1 clears it.
- A TH event and int_ack in the same cycle leave ext_int set.
REQ-029 Clearing CTRLk[7] SHALL NOT clear a pending ext_int.
REQ-030 A TH falling edge that coincides with the write setting CTRLk[7] SHALL NOT raise ext_int (the enable takes effect from the next cycle).

Reset
REQ-031 While reset_n=0, all of the following SHALL hold asynchronously:
- DATAk = 0x00, CTRLk = 0x00, TXDk = 0xFF, SCTRLk = 0x00.
- THk_d = 1.
- ext_int = 0, cpu_dtack = 0, cpu_dout = 0x00.
- Consequently pk_dir = 0 (all pins inputs) and pk_out = 0.
REQ-032 A bus cycle in progress when reset asserts SHALL be abandoned; after release, a still-high cpu_sel SHALL start a fresh access.

Verification
REQ-033 Version read, NO_EXP=1, HW_VER=1, overseas=1, pal=0: read addr 0 -> cpu_dout 0xA1, cpu_dtack high one cycle after cpu_sel.
REQ-034 Mixed-direction data: write CTRL1=0x40, write DATA1=0x40, p1_in=0x15 -> p1_dir=0x40, p1_out=0x40, DATA1 read = 0x55.
REQ-035 TH interrupt on port 2: write CTRL2=0x80, drive p2_in[6] 1 -> 0 -> ext_int=1 next cycle, and it remains 1 until an int_ack pulse.
REQ-036 Ack/edge collision: with ext_int=1, assert int_ack in the same cycle as a new TH fall on port 3 (CTRL3=0x80) -> ext_int stays 1.
REQ-037 Long cpu_sel: hold a write to TXD1=0x3C for 10 cycles -> exactly one commit, TXD1 reads 0x3C, RXD1 reads 0x00, SCTRL1 written 0xFF reads 0xF8.
REQ-038 Reset mid-cycle: assert reset_n=0 during a DATA1 write -> DATA1=0x00, TXD1=0xFF, cpu_dtack=0 immediately; after release with cpu_sel still high -> new access, dtack one cycle later.
